idexe_hazard_reg: RTL and testbench

//  ID->EXE pipeline register with integrated hazard interlock. Captures decode-stage outputs each cycle.

---
 rtl/idexe_hazard_reg.sv | 233 +++++++++++++++++++++++
 tb/tb_idexe_hazard_reg.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idexe_hazard_reg.sv
// Purpose : ID->EXE pipeline register with load-use / branch-in-ID hazard interlock.
// Latency : 1 cycle ID->EXE; StallFront_OUT is combinational in the same cycle.
// Backpr. : Stall_IN holds every register; an interlock bubble freezes PC and IF/ID via StallFront_OUT.
//
// Ports:
//   CLOCK, RESET (synchronous, active-low)
//   *_IN   decode-stage fields, Valid_IN marks a real instruction
//   *_OUT  registered EXE copies of the same fields, Valid_OUT marks a real instruction
//   Flush_IN        squash: EXE takes a bubble, interlock returns to RUN
//   Stall_IN        downstream freeze: hold all state
//   StallFront_OUT  freeze PC and IF/ID this cycle
//   BubbleCount_OUT / StallCount_OUT  performance counters
//
// Optional feature macro: IDEXE_PERF_EN
//   defined   : saturating 32-bit counters of interlock bubbles and Stall_IN cycles
//   undefined : both counter ports read zero and no counter flops exist
module idexe_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              Valid_IN,
    input  logic [DATA_W-1:0] OperandA_IN,
    input  logic [DATA_W-1:0] OperandB_IN,
    input  logic [DATA_W-1:0] MemWriteData_IN,
    input  logic [5:0]        ALUControl_IN,
    input  logic [4:0]        ShiftAmount_IN,
    input  logic              MemRead_IN,
    input  logic              MemWrite_IN,
    input  logic [REG_W-1:0]  WriteRegister_IN,
    input  logic              WriteEnable_IN,
    input  logic [REG_W-1:0]  RegisterRS_IN,
    input  logic [REG_W-1:0]  RegisterRT_IN,
    input  logic              Immed_IN,
    input  logic              Branch_IN,
    input  logic              JumpReg_IN,
    input  logic              Syscall_IN,
    input  logic              Flush_IN,
    input  logic              Stall_IN,
    output logic              Valid_OUT,
    output logic [DATA_W-1:0] OperandA_OUT,
    output logic [DATA_W-1:0] OperandB_OUT,
    output logic [DATA_W-1:0] MemWriteData_OUT,
    output logic [5:0]        ALUControl_OUT,
    output logic [4:0]        ShiftAmount_OUT,
    output logic              MemRead_OUT,
    output logic              MemWrite_OUT,
    output logic [REG_W-1:0]  WriteRegister_OUT,
    output logic              WriteEnable_OUT,
    output logic [REG_W-1:0]  RegisterRS_OUT,
    output logic [REG_W-1:0]  RegisterRT_OUT,
    output logic              Immed_OUT,
    output logic              Branch_OUT,
    output logic              JumpReg_OUT,
    output logic              Syscall_OUT,
    output logic              StallFront_OUT,
    output logic [31:0]       BubbleCount_OUT,
    output logic [31:0]       StallCount_OUT
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [DATA_W-1:0] mem_wdata;
        logic [5:0]        alu_ctrl;
        logic [4:0]        shamt;
        logic              mem_read;
        logic              mem_write;
        logic [REG_W-1:0]  wr_reg;
        logic              wr_en;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic              immed;
        logic              branch;
        logic              jump_reg;
        logic              syscall;
    } exe_t;

    // BUB2 is the second bubble owed when a branch in ID depends on a load in EXE.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUB2 = 1'b1
    } state_t;

    exe_t   exe_q, exe_d, id_dat;
    state_t state_q, state_d;
    logic   stall_front;

    // ------------------------------------------------------------------
    // Gather decode fields into one bundle
    // ------------------------------------------------------------------
    always_comb begin
        id_dat           = '0;
        id_dat.valid     = Valid_IN;
        id_dat.op_a      = OperandA_IN;
        id_dat.op_b      = OperandB_IN;
        id_dat.mem_wdata = MemWriteData_IN;
        id_dat.alu_ctrl  = ALUControl_IN;
        id_dat.shamt     = ShiftAmount_IN;
        id_dat.mem_read  = MemRead_IN;
        id_dat.mem_write = MemWrite_IN;
        id_dat.wr_reg    = WriteRegister_IN;
        id_dat.wr_en     = WriteEnable_IN;
        id_dat.rs        = RegisterRS_IN;
        id_dat.rt        = RegisterRT_IN;
        id_dat.immed     = Immed_IN;
        id_dat.branch    = Branch_IN;
        id_dat.jump_reg  = JumpReg_IN;
        id_dat.syscall   = Syscall_IN;
    end

    // ------------------------------------------------------------------
    // Hazard detection against the instruction currently in EXE
    // ------------------------------------------------------------------
    logic uses_rt, ctrl_xfer, match, hz_one, hz_two, hz_any;

    // RT is an ALU source unless the op is immediate; stores and branches
    // still read it. jr/jalr read RS only.
    assign uses_rt   = (!Immed_IN | MemWrite_IN | Branch_IN) & !JumpReg_IN;
    assign ctrl_xfer = Branch_IN | JumpReg_IN;
    assign match     = exe_q.valid & exe_q.wr_en & (exe_q.wr_reg != '0) &
                       ((exe_q.wr_reg == RegisterRS_IN) |
                        (uses_rt & (exe_q.wr_reg == RegisterRT_IN)));

    // One bubble: load feeding ALU (LU) or ALU result feeding a branch (BA).
    // Two bubbles: load feeding a branch (BL), since the branch resolves in ID.
    assign hz_one = Valid_IN & match & (exe_q.mem_read ^ ctrl_xfer);
    assign hz_two = Valid_IN & match & exe_q.mem_read & ctrl_xfer;
    assign hz_any = hz_one | hz_two;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        exe_d       = exe_q;
        state_d     = state_q;
        stall_front = 1'b0;
        if (Flush_IN) begin
            exe_d   = '0;
            state_d = ST_RUN;
        end else if (Stall_IN) begin
            stall_front = 1'b1;
        end else if (state_q == ST_BUB2) begin
            // Load has moved to MEM; the second bubble is unconditional.
            exe_d       = '0;
            state_d     = ST_RUN;
            stall_front = 1'b1;
        end else if (hz_any) begin
            exe_d       = '0;
            stall_front = 1'b1;
            if (hz_two) begin
                state_d = ST_BUB2;
            end
        end else begin
            exe_d = id_dat;
        end
    end

    // Front end is not frozen while the pipe is being reset.
    assign StallFront_OUT = RESET & stall_front;

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            exe_q   <= '0;
            state_q <= ST_RUN;
        end else begin
            exe_q   <= exe_d;
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef IDEXE_PERF_EN
    logic [31:0] bub_cnt_q, bub_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        bub_inc;

    // Only interlock bubbles count; flush bubbles and frozen cycles do not.
    assign bub_inc = !Flush_IN & !Stall_IN & ((state_q == ST_BUB2) | hz_any);

    always_comb begin
        bub_cnt_d   = bub_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (bub_inc && (bub_cnt_q != 32'hFFFF_FFFF)) begin
            bub_cnt_d = bub_cnt_q + 32'd1;
        end
        if (Stall_IN && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            bub_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            bub_cnt_q   <= bub_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign BubbleCount_OUT = bub_cnt_q;
    assign StallCount_OUT  = stall_cnt_q;
`else
    assign BubbleCount_OUT = 32'd0;
    assign StallCount_OUT  = 32'd0;
`endif

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign Valid_OUT         = exe_q.valid;
    assign OperandA_OUT      = exe_q.op_a;
    assign OperandB_OUT      = exe_q.op_b;
    assign MemWriteData_OUT  = exe_q.mem_wdata;
    assign ALUControl_OUT    = exe_q.alu_ctrl;
    assign ShiftAmount_OUT   = exe_q.shamt;
    assign MemRead_OUT       = exe_q.mem_read;
    assign MemWrite_OUT      = exe_q.mem_write;
    assign WriteRegister_OUT = exe_q.wr_reg;
    assign WriteEnable_OUT   = exe_q.wr_en;
    assign RegisterRS_OUT    = exe_q.rs;
    assign RegisterRT_OUT    = exe_q.rt;
    assign Immed_OUT         = exe_q.immed;
    assign Branch_OUT        = exe_q.branch;
    assign JumpReg_OUT       = exe_q.jump_reg;
    assign Syscall_OUT       = exe_q.syscall;

endmodule

// File: tb/tb_idexe_hazard_reg.sv
// Purpose : self-checking bench for idexe_hazard_reg (directed scenarios + randomized stream).
// Latency : model advances once per posedge; outputs compared at every negedge.
// Backpr. : front end holds the ID instruction whenever the expected StallFront was high at the edge.
module tb_idexe_hazard_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] wdata;
        logic [5:0]  alu;
        logic [4:0]  shamt;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  wr_reg;
        logic        wr_en;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        immed;
        logic        branch;
        logic        jump_reg;
        logic        syscall;
    } ins_t;

    logic CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    ins_t id;
    logic rst_n, flush, stall;

    logic        v_o, mr_o, mw_o, we_o, im_o, br_o, jr_o, sc_o, front_o;
    logic [31:0] a_o, b_o, wd_o, bub_o, stc_o;
    logic [5:0]  alu_o;
    logic [4:0]  sh_o, wr_o, rs_o, rt_o;

    idexe_hazard_reg #(.DATA_W(32), .REG_W(5)) dut (
        .CLOCK(CLOCK), .RESET(rst_n),
        .Valid_IN(id.valid), .OperandA_IN(id.op_a), .OperandB_IN(id.op_b),
        .MemWriteData_IN(id.wdata), .ALUControl_IN(id.alu), .ShiftAmount_IN(id.shamt),
        .MemRead_IN(id.mem_read), .MemWrite_IN(id.mem_write), .WriteRegister_IN(id.wr_reg),
        .WriteEnable_IN(id.wr_en), .RegisterRS_IN(id.rs), .RegisterRT_IN(id.rt),
        .Immed_IN(id.immed), .Branch_IN(id.branch), .JumpReg_IN(id.jump_reg),
        .Syscall_IN(id.syscall), .Flush_IN(flush), .Stall_IN(stall),
        .Valid_OUT(v_o), .OperandA_OUT(a_o), .OperandB_OUT(b_o), .MemWriteData_OUT(wd_o),
        .ALUControl_OUT(alu_o), .ShiftAmount_OUT(sh_o), .MemRead_OUT(mr_o),
        .MemWrite_OUT(mw_o), .WriteRegister_OUT(wr_o), .WriteEnable_OUT(we_o),
        .RegisterRS_OUT(rs_o), .RegisterRT_OUT(rt_o), .Immed_OUT(im_o), .Branch_OUT(br_o),
        .JumpReg_OUT(jr_o), .Syscall_OUT(sc_o), .StallFront_OUT(front_o),
        .BubbleCount_OUT(bub_o), .StallCount_OUT(stc_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: what EXE must hold, and how many bubbles are still owed
    // ------------------------------------------------------------------
    ins_t        m_exe;
    int          m_owed;
    logic [31:0] m_bub, m_stc;
    logic        m_front_at_edge;
    logic        model_ok = 1'b0;

    // Bubbles a decode instruction needs behind the instruction now in EXE.
    function automatic int bubbles_needed(input ins_t exe, input ins_t dec);
        logic reads_rt, hit, cx;
        if (!dec.valid || !exe.valid || !exe.wr_en || exe.wr_reg == 5'd0) return 0;
        reads_rt = dec.jump_reg ? 1'b0 : (!dec.immed || dec.mem_write || dec.branch);
        hit = (exe.wr_reg == dec.rs) || (reads_rt && exe.wr_reg == dec.rt);
        if (!hit) return 0;
        cx = dec.branch || dec.jump_reg;
        if (exe.mem_read && cx) return 2;
        if (exe.mem_read || cx) return 1;
        return 0;
    endfunction

    function automatic logic front_now();
        if (!rst_n || flush) return 1'b0;
        if (stall) return 1'b1;
        if (m_owed > 0) return 1'b1;
        return bubbles_needed(m_exe, id) > 0;
    endfunction

    always @(posedge CLOCK) begin
        ins_t        n_exe;
        int          n_owed, need;
        logic [31:0] n_bub, n_stc;
        n_exe  = m_exe;
        n_owed = m_owed;
        n_bub  = m_bub;
        n_stc  = m_stc;
        if (!rst_n) begin
            n_exe = '0; n_owed = 0; n_bub = 0; n_stc = 0;
        end else begin
            if (stall && m_stc != 32'hFFFF_FFFF) n_stc = m_stc + 1;
            if (flush) begin
                n_exe = '0; n_owed = 0;
            end else if (stall) begin
                n_exe = m_exe;
            end else if (m_owed > 0) begin
                n_exe = '0; n_owed = m_owed - 1;
                if (m_bub != 32'hFFFF_FFFF) n_bub = m_bub + 1;
            end else begin
                need = bubbles_needed(m_exe, id);
                if (need > 0) begin
                    n_exe = '0; n_owed = need - 1;
                    if (m_bub != 32'hFFFF_FFFF) n_bub = m_bub + 1;
                end else begin
                    n_exe = id;
                end
            end
        end
        m_front_at_edge <= front_now();
        m_exe    <= n_exe;
        m_owed   <= n_owed;
        m_bub    <= n_bub;
        m_stc    <= n_stc;
        if (!rst_n) model_ok <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Compare process: every negedge once the model has seen a reset
    // ------------------------------------------------------------------
    always @(negedge CLOCK) begin
        ins_t got;
        if (model_ok) begin
            got = '{v_o, a_o, b_o, wd_o, alu_o, sh_o, mr_o, mw_o, wr_o, we_o,
                    rs_o, rt_o, im_o, br_o, jr_o, sc_o};
            checks++;
            if (got !== m_exe) begin
                errors++;
                $display("FAIL exe_regs: got %h expected %h at %0t", got, m_exe, $time);
            end
            chk("stall_front", {31'd0, front_o}, {31'd0, front_now()});
`ifdef IDEXE_PERF_EN
            chk("bubble_count", bub_o, m_bub);
            chk("stall_count", stc_o, m_stc);
`else
            chk("bubble_count", bub_o, 32'd0);
            chk("stall_count", stc_o, 32'd0);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge CLOCK);
        #2;
    endtask

    function automatic ins_t mk(input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                                input logic we, input logic ld, input logic imm, input logic br);
        ins_t i;
        i = '0;
        i.valid = 1'b1; i.wr_reg = wr; i.rs = rs; i.rt = rt; i.wr_en = we;
        i.mem_read = ld; i.immed = imm; i.branch = br;
        i.op_a = {27'd0, rs} + 32'h100; i.op_b = {27'd0, rt} + 32'h200; i.alu = 6'h20;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.valid     = ($urandom_range(0, 7) != 0);
        i.op_a      = $urandom;
        i.op_b      = $urandom;
        i.wdata     = $urandom;
        i.alu       = 6'($urandom_range(0, 63));
        i.shamt     = 5'($urandom_range(0, 31));
        i.mem_read  = ($urandom_range(0, 2) == 0);
        i.mem_write = ($urandom_range(0, 5) == 0);
        i.wr_reg    = 5'($urandom_range(0, 3));
        i.wr_en     = ($urandom_range(0, 3) != 0);
        i.rs        = 5'($urandom_range(0, 3));
        i.rt        = 5'($urandom_range(0, 3));
        i.immed     = 1'($urandom_range(0, 1));
        i.branch    = ($urandom_range(0, 4) == 0);
        i.jump_reg  = ($urandom_range(0, 7) == 0);
        i.syscall   = ($urandom_range(0, 15) == 0);
        return i;
    endfunction

    ins_t LW8, ADD98, ADD8, BEQ8, LW0, RD0, LW9, ADDI, ADD5;

    initial begin
        LW8   = mk(5'd8, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        ADD98 = mk(5'd9, 5'd8, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        ADD8  = mk(5'd8, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        BEQ8  = mk(5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        LW0   = mk(5'd0, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        RD0   = mk(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        LW9   = mk(5'd9, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        ADDI  = mk(5'd9, 5'd8, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        ADD5  = mk(5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0; flush = 1'b0; stall = 1'b0; id = '0;
        tick(); tick();
        @(negedge CLOCK);
        chk("reset_valid", {31'd0, v_o}, 32'd0);
        chk("reset_front", {31'd0, front_o}, 32'd0);
        chk("reset_bubcnt", bub_o, 32'd0);

        // Load-use: lw $8 then add $9,$8,$10
        tick(); rst_n = 1'b1; id = LW8;
        tick(); id = ADD98;
        @(negedge CLOCK); chk("lu_front", {31'd0, front_o}, 32'd1);
        tick();
        @(negedge CLOCK); chk("lu_bubble", {31'd0, v_o}, 32'd0);
        chk("lu_front_drop", {31'd0, front_o}, 32'd0);
        tick(); id = ADD8;
        @(negedge CLOCK); chk("lu_capture", {26'd0, v_o, wr_o}, {26'd0, 1'b1, 5'd9});

        // ALU result feeding a branch: one bubble
        tick(); id = BEQ8;
        @(negedge CLOCK); chk("ba_front", {31'd0, front_o}, 32'd1);
        tick();
        @(negedge CLOCK); chk("ba_bubble", {30'd0, v_o, front_o}, 32'd0);

        // Load feeding a branch: two bubbles
        tick(); id = LW8;
        tick(); id = BEQ8;
        @(negedge CLOCK); chk("bl_front1", {31'd0, front_o}, 32'd1);
        tick();
        @(negedge CLOCK); chk("bl_front2", {30'd0, v_o, front_o}, 32'd1);
        tick();
        @(negedge CLOCK); chk("bl_release", {30'd0, v_o, front_o}, 32'd0);

        // Register 0 and immediate RT never interlock
        tick(); id = LW0;
        tick(); id = RD0;
        @(negedge CLOCK); chk("reg0_no_stall", {31'd0, front_o}, 32'd0);
        tick(); id = LW9;
        tick(); id = ADDI;
        @(negedge CLOCK); chk("immed_rt_no_stall", {31'd0, front_o}, 32'd0);

        // Flush while the second load-branch bubble is owed
        tick(); id = LW8;
        tick(); id = BEQ8;
        tick(); flush = 1'b1;
        @(negedge CLOCK); chk("flush_front", {31'd0, front_o}, 32'd0);
        tick(); flush = 1'b0; id = '0;
        @(negedge CLOCK); chk("flush_bubble", {30'd0, v_o, front_o}, 32'd0);
`ifdef IDEXE_PERF_EN
        chk("bubble_total", bub_o, 32'd5);
`endif

        // Three-cycle downstream stall holds EXE
        tick(); id = ADD5;
        tick(); stall = 1'b1; id = rand_ins();
        @(negedge CLOCK); chk("stall_front", {31'd0, front_o}, 32'd1);
        tick(); tick(); tick(); stall = 1'b0; id = '0;
        @(negedge CLOCK); chk("stall_hold", {26'd0, v_o, wr_o}, {26'd0, 1'b1, 5'd5});
`ifdef IDEXE_PERF_EN
        chk("stall_count3", stc_o, 32'd3);
`endif

        // Reset mid-stream
        tick(); id = ADD5;
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1; id = '0;
        @(negedge CLOCK); chk("midreset", {26'd0, v_o, wr_o}, 32'd0);
        chk("midreset_cnt", bub_o | stc_o, 32'd0);

        // Randomized stream; ID is held whenever the front end was frozen
        for (int n = 0; n < 4000; n++) begin
            tick();
            rst_n = ($urandom_range(0, 99) != 0);
            flush = ($urandom_range(0, 15) == 0);
            stall = ($urandom_range(0, 9) == 0);
            if (!m_front_at_edge) id = rand_ins();
        end
        tick();
        @(negedge CLOCK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
